// File: rtl/fp_exp_align.sv
`default_nettype none
// ============================================================================
// Module      : fp_exp_align
// Description : Floating-point exponent alignment. Selects the larger-exponent
//               operand and right-shifts the smaller significand one bit per
//               cycle, collecting guard, round and sticky bits.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_exp_align #(
    parameter int MAN_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [8:0]         exp_a,
    input  logic [MAN_W-1:0]   man_a,
    input  logic [8:0]         exp_b,
    input  logic [MAN_W-1:0]   man_b,
    output logic               busy,
    output logic               done,
    output logic               swap,
    output logic [8:0]         exp_out,
    output logic [MAN_W-1:0]   man_big,
    output logic [MAN_W+2:0]   man_small
);

    // Beyond this distance every bit of the small significand lands in sticky.
    localparam logic [8:0] c_D_MAX = 9'(MAN_W + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_swap;
    logic [8:0]         r_exp_out;
    logic [MAN_W-1:0]   r_man_big;
    logic [MAN_W+2:0]   r_man_small;
    logic [8:0]         r_d;
    logic [8:0]         r_exp_small;

    logic               w_swap;
    logic [8:0]         w_exp_max;
    logic [8:0]         w_exp_min;
    logic [8:0]         w_d;
    logic [MAN_W-1:0]   w_man_big;
    logic [MAN_W-1:0]   w_man_sm;
    logic               w_flush;

    always_comb begin
        w_swap    = (exp_b > exp_a);
        w_exp_max = w_swap ? exp_b : exp_a;
        w_exp_min = w_swap ? exp_a : exp_b;
        w_d       = w_exp_max - w_exp_min;
        w_man_big = w_swap ? man_b : man_a;
        w_man_sm  = w_swap ? man_a : man_b;
        w_flush   = (w_d > c_D_MAX);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_d == 9'd0 || w_flush) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (r_d == 9'd1) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_swap      <= 1'b0;
            r_exp_out   <= 9'd0;
            r_man_big   <= '0;
            r_man_small <= '0;
            r_d         <= 9'd0;
            r_exp_small <= 9'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_swap      <= w_swap;
                        r_exp_out   <= w_exp_max;
                        r_man_big   <= w_man_big;
                        r_d         <= w_d;
                        r_exp_small <= w_exp_min;
                        if (w_flush) begin
                            r_man_small <= {{(MAN_W+2){1'b0}}, |w_man_sm};
                        end else begin
                            r_man_small <= {w_man_sm, 3'b000};
                        end
                    end
                end
                SHIFT: begin
                    // Bit 0 is sticky: it absorbs everything shifted past it.
                    r_man_small <= {1'b0, r_man_small[MAN_W+2:2],
                                    r_man_small[1] | r_man_small[0]};
                    r_exp_small <= r_exp_small + 9'd1;
                    r_d         <= r_d - 9'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign swap      = r_swap;
    assign exp_out   = r_exp_out;
    assign man_big   = r_man_big;
    assign man_small = r_man_small;

endmodule
`default_nettype wire

// File: tb/tb_fp_exp_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_exp_align
// Description : Self-checking bench for fp_exp_align against an arithmetic
//               reference model of alignment with sticky collection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_exp_align;

    localparam int MAN_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [8:0]         exp_a;
    logic [MAN_W-1:0]   man_a;
    logic [8:0]         exp_b;
    logic [MAN_W-1:0]   man_b;
    logic               busy;
    logic               done;
    logic               swap;
    logic [8:0]         exp_out;
    logic [MAN_W-1:0]   man_big;
    logic [MAN_W+2:0]   man_small;

    int n_checks = 0;
    int n_fail   = 0;

    fp_exp_align #(.MAN_W(MAN_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .exp_a     (exp_a),
        .man_a     (man_a),
        .exp_b     (exp_b),
        .man_b     (man_b),
        .busy      (busy),
        .done      (done),
        .swap      (swap),
        .exp_out   (exp_out),
        .man_big   (man_big),
        .man_small (man_small)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Shifting {sm,000} right by d: bits above 0 are the plain quotient, bit 0
    // is the OR of every bit at or below position d of the original vector.
    function automatic logic [63:0] ref_small(input logic [MAN_W-1:0] sm, input int d);
        logic [63:0] v;
        logic [63:0] mask;
        if (d > MAN_W + 2) return (sm != 0) ? 64'd1 : 64'd0;
        v    = 64'(sm) << 3;
        mask = (64'd1 << (d + 1)) - 64'd1;
        return ((v >> d) & ~64'd1) | (((v & mask) != 0) ? 64'd1 : 64'd0);
    endfunction

    task automatic run(input logic [8:0] ea, input logic [MAN_W-1:0] ma,
                       input logic [8:0] eb, input logic [MAN_W-1:0] mb,
                       input bit poke_busy, input bit poke_done);
        bit               sw;
        int               d;
        int               lat;
        int               cyc;
        logic [8:0]       emax;
        logic [MAN_W-1:0] big;
        logic [MAN_W-1:0] sm;
        logic [63:0]      want_small;
        sw   = (eb > ea);
        emax = sw ? eb : ea;
        d    = sw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
        big  = sw ? mb : ma;
        sm   = sw ? ma : mb;
        lat  = (d == 0 || d > MAN_W + 2) ? 1 : 1 + d;
        want_small = ref_small(sm, d);

        @(negedge clk);
        exp_a = ea; man_a = ma; exp_b = eb; man_b = mb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 64) begin
            if (poke_busy && cyc == 1) begin
                start = 1'b1;
                exp_a = 9'($urandom); exp_b = 9'($urandom);
                man_a = MAN_W'($urandom); man_b = MAN_W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency",   64'(cyc),       64'(lat));
        check("swap",      64'(swap),      64'(sw));
        check("exp_out",   64'(exp_out),   64'(emax));
        check("man_big",   64'(man_big),   64'(big));
        check("man_small", 64'(man_small), want_small);

        if (poke_done) begin
            start = 1'b1;
            exp_a = 9'($urandom); exp_b = 9'($urandom);
            man_a = MAN_W'($urandom); man_b = MAN_W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        exp_a = 9'($urandom); man_b = MAN_W'($urandom);
        check("done_pulse", 64'(done),      64'd0);
        check("idle_busy",  64'(busy),      64'd0);
        check("hold_exp",   64'(exp_out),   64'(emax));
        check("hold_small", 64'(man_small), want_small);
    endtask

    initial begin
        logic [8:0]       ea;
        logic [8:0]       eb;
        logic [MAN_W-1:0] ma;
        logic [MAN_W-1:0] mb;
        bit               seen_done;

        rst = 1'b1; start = 1'b0;
        exp_a = '0; exp_b = '0; man_a = '0; man_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_swap",  64'(swap),      64'd0);
        check("rst_exp",   64'(exp_out),   64'd0);
        check("rst_big",   64'(man_big),   64'd0);
        check("rst_small", 64'(man_small), 64'd0);
        rst = 1'b0;

        run(9'd127, 24'h800000, 9'd127, 24'hC00000, 1'b0, 1'b0);
        run(9'd130, 24'h800000, 9'd128, 24'hC00000, 1'b0, 1'b0);
        run(9'd100, 24'h800001, 9'd140, 24'hA00000, 1'b0, 1'b0);
        run(9'd26,  24'h912345, 9'd0,   24'h800000, 1'b0, 1'b0);
        run(9'd26,  24'h912345, 9'd0,   24'h800001, 1'b0, 1'b0);
        run(9'd0,   24'h800003, 9'd25,  24'hFFFFFF, 1'b1, 1'b1);
        run(9'd27,  24'h800000, 9'd0,   24'h000000, 1'b0, 1'b1);
        run(9'h1FF, 24'hABCDEF, 9'h1F0, 24'h876543, 1'b1, 1'b0);
        run(9'h1FF, 24'h000001, 9'h1FF, 24'h000002, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            ea = 9'($urandom);
            case ($urandom_range(0, 4))
                0:       eb = ea;
                1:       eb = ea + 9'($urandom_range(1, 30));
                2:       eb = ea - 9'($urandom_range(1, 30));
                3:       eb = 9'h1FF;
                default: eb = 9'($urandom);
            endcase
            ma = MAN_W'($urandom);
            mb = ($urandom_range(0, 5) == 0) ? '0 : MAN_W'($urandom);
            run(ea, ma, eb, mb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset during an in-flight alignment: cycle T is the start cycle.
        seen_done = 1'b0;
        @(negedge clk);
        exp_a = 9'd50; exp_b = 9'd40;
        man_a = MAN_W'($urandom); man_b = MAN_W'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;                               // T+1
        seen_done |= done;
        @(negedge clk);
        start = 1'b1; exp_a = 9'd3; exp_b = 9'd9;   // T+2
        seen_done |= done;
        @(negedge clk);
        start = 1'b0;                               // T+3
        seen_done |= done;
        check("abort_busy_pre", 64'(busy),    64'd1);
        check("abort_exp_pre",  64'(exp_out), 64'd50);
        @(negedge clk);
        rst = 1'b1;                                 // T+4
        seen_done |= done;
        @(negedge clk);
        rst = 1'b0;                                 // T+5
        check("abort_busy",  64'(busy),      64'd0);
        check("abort_done",  64'(done),      64'd0);
        check("abort_swap",  64'(swap),      64'd0);
        check("abort_exp",   64'(exp_out),   64'd0);
        check("abort_big",   64'(man_big),   64'd0);
        check("abort_small", 64'(man_small), 64'd0);
        for (int k = 0; k < 20; k++) begin
            seen_done |= done;
            @(negedge clk);
        end
        check("abort_no_done", 64'(seen_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_exp_align.md
FP_EXP_ALIGN -- requirements
Module: fp_exp_align

Interface
REQ-001 The block SHALL have parameter MAN_W, default 24, giving the significand width including the hidden bit.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, an alignment request, sampled only in IDLE.
REQ-005 The block SHALL have port exp_a, input, 9, the biased exponent of operand A (unsigned).
REQ-006 The block SHALL have port man_a, input, MAN_W, the significand of operand A.
REQ-007 The block SHALL have port exp_b, input, 9, the biased exponent of operand B (unsigned).
REQ-008 The block SHALL have port man_b, input, MAN_W, the significand of operand B.
REQ-009 The block SHALL have port busy, output, 1, which is high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1, a one-cycle result-valid pulse.
REQ-011 The block SHALL have port swap, output, 1, which is 1 when B has the larger exponent.
REQ-012 The block SHALL have port exp_out, output, 9, the common exponent after alignment.
REQ-013 The block SHALL have port man_big, output, MAN_W, the significand of the larger-exponent operand.
REQ-014 The block SHALL have port man_small, output, MAN_W+3, the aligned smaller significand followed by guard, round and sticky bits.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE with start=1, one edge SHALL capture the operands and set swap = (exp_b > exp_a), comparing unsigned 9-bit values.
- On equal exponents, swap SHALL be 0 and A is the larger operand.
REQ-017 On capture, the block SHALL load exp_out = max(exp), man_big = larger operand's significand, man_small = {smaller significand, 3'b000}, d = max(exp) - min(exp), and an internal small-operand exponent = min(exp).
REQ-018 On capture, the next state SHALL be selected as follows:
- d=0: DONE.
- d > MAN_W+2: DONE with the flush rule applied.
- otherwise: SHIFT.
REQ-019 Flush SHALL set man_small = {(MAN_W+2) zeros, OR-reduce(smaller significand)}.
REQ-020 Each SHIFT cycle SHALL apply the following updates:
- man_small <= {1'b0, man_small[MAN_W+2:2], man_small[1] | man_small[0]}, so the sticky bit accumulates every bit shifted out.
- The small exponent SHALL be incremented by 1.
- d SHALL be decremented by 1.
REQ-021 SHIFT SHALL go to DONE on the edge where d goes from 1 to 0; exactly d shift edges SHALL occur.
REQ-022 done SHALL be 1 only during the DONE cycle, and the block SHALL return to IDLE on the following edge.
REQ-023 Latency: done SHALL be asserted in cycle T+1+d for 1<=d<=MAN_W+2, and in cycle T+1 for d=0 and for flush, where T is the start cycle.
REQ-024 Outputs swap, exp_out, man_big and man_small SHALL hold their values from DONE until the next accepted start.
REQ-025 A start asserted while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-026 A start asserted in the same cycle as DONE SHALL be ignored.
REQ-027 Exponent arithmetic SHALL be 9-bit, with no wrap: the small exponent never exceeds exp_out.
REQ-028 Special-value exponents, including 9'h1FF, SHALL be treated as ordinary unsigned values.

Reset
REQ-029 When rst=1 at an edge, the block SHALL enter IDLE, clear all outputs to 0 (busy=0, done=0), and clear the internal counter.
REQ-030 rst SHALL take priority over start and over any in-progress SHIFT; an aborted alignment SHALL never produce done.

Verification
REQ-031 Equal exponents: exp_a=exp_b=127, man_a=24'h800000, man_b=24'hC00000 -> done at T+1, swap=0, exp_out=127, man_big=24'h800000, man_small=27'h6000000.
REQ-032 d=2: exp_a=130, man_a=24'h800000, exp_b=128, man_b=24'hC00000 -> done at T+3, swap=0, exp_out=130, man_small=27'h1800000.
REQ-033 Flush with swap: exp_a=100, man_a=24'h800001, exp_b=140, man_b=24'hA00000 -> done at T+1, swap=1, exp_out=140, man_big=24'hA00000, man_small=27'h0000001.
REQ-034 Boundary d=26: exp_a=26, exp_b=0, man_b=24'h800000 -> done at T+27, man_small=27'h0000001; the same case with man_b=24'h800001 also gives man_small=27'h0000001 via sticky.
REQ-035 Reset and busy interaction: exp_a=50, exp_b=40, with start re-pulsed at T+2 (ignored) and rst=1 at T+4 -> busy=0 and all outputs 0 from T+5, and done never asserts.
